i2c_reg_ctrl: RTL and testbench
===============================

# i2c_reg_ctrl

Register-bank controller behind `i2c_target`. It turns the target's byte stream into pointer-addressed, auto-incrementing accesses to an internal bank of `NUM_REGS` 8-bit registers, and serves the read bytes the target requests. A second, local fabric port shares the same bank under fixed-priority arbitration, with I2C taking precedence. Write notifications let fabric logic react to host updates.

## Interface
- `NUM_REGS`, 16: number of 8-bit registers; power of two, 2..256.
- `IDX_W`, `$clog2(NUM_REGS)`: register index width; derived, do not override.

- `clk` in 1: single clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `i2c_rx_byte_data_i` in 8: byte received from `i2c_target`.
- `i2c_rx_byte_valid_i` in 1: one-cycle strobe, rx byte valid.
- `i2c_tx_byte_req_i` in 1: one-cycle strobe, target needs the next read byte.
- `i2c_tx_byte_data_o` out 8: read byte to `i2c_target`.
- `i2c_tx_byte_valid_o` out 1: one-cycle strobe, tx byte valid.
- `i2c_transaction_start_i` in 1: strobe, address matched (start or repeated start).
- `i2c_transaction_stop_i` in 1: strobe, stop condition on the bus.
- `fab_req_i` in 1: fabric access request, level, held until ack.
- `fab_we_i` in 1: 1 = write, 0 = read; stable while `fab_req_i` is high.
- `fab_addr_i` in IDX_W: fabric register index.
- `fab_wdata_i` in 8: fabric write data.
- `fab_rdata_o` out 8: fabric read data, valid while `fab_ack_o` is high.
- `fab_ack_o` out 1: one-cycle access-complete strobe.
- `reg_wr_o` out 1: one-cycle strobe, the I2C host wrote a register.
- `reg_wr_idx_o` out IDX_W: index written, valid with `reg_wr_o`.

## Operation
- **States:** IDLE, PTR (next rx byte is the pointer), DATA (rx bytes are data).
- **Reset:** all registers 0, `ptr` 0, state IDLE, every output 0.
- **Transitions:**
  - `i2c_transaction_start_i` in any state → PTR; `ptr` is retained.
  - `i2c_transaction_stop_i` → IDLE.
  - Start and stop in the same cycle → PTR (start wins).
- **rx byte in IDLE:** ignored, no state change.
- **rx byte in PTR:** `ptr <= byte[IDX_W-1:0]` (upper bits dropped), go to DATA; no register write.
- **rx byte in DATA:** `reg[ptr] <= byte`, `ptr <= ptr+1` mod NUM_REGS (wraps from NUM_REGS-1 to 0), pulse `reg_wr_o` with `reg_wr_idx_o` = old `ptr`.
- **tx request:**
  - In PTR or DATA: `i2c_tx_byte_data_o <= reg[ptr]`, `i2c_tx_byte_valid_o` pulses, `ptr <= ptr+1` with wrap. A request in PTR moves the state to DATA, so a read after a repeated start continues from the retained pointer.
  - In IDLE: still answered with `reg[ptr]` so the target never stalls, but `ptr` does not change.
- **rx and tx strobes in the same cycle:** protocol violation; rx is processed, tx is answered with pre-update `reg[ptr]`, and `ptr` advances once.
- **Event order with stop:** if a stop or start arrives in the same cycle as an rx byte or tx request, the byte or request is processed first using the current state, then the transition applies.
- **Arbitration:**
  - One bank access per cycle.
  - An I2C strobe (rx in PTR/DATA, or tx) always wins.
  - Fabric is granted in a cycle where `fab_req_i` && no I2C strobe && !`fab_ack_o`.
  - Granted write updates `reg[fab_addr_i]`. Granted read captures `reg[fab_addr_i]` into `fab_rdata_o`.
  - `fab_ack_o` is high the cycle after the grant.
- **Same-index conflict:** an I2C write and a fabric write to the same index in the same cycle → I2C writes first, fabric is granted the next cycle, and the fabric value remains.
- **Read-data hold:** `fab_rdata_o` holds its last value outside ack.

## Timing
- **I2C write:** `rx_valid` in cycle N → register updated and `reg_wr_o` high in cycle N+1.
- **I2C read:** `tx_byte_req` in N → `tx_byte_valid` and data in N+1. This is one-cycle latency, well inside the SCL low phase.
- **Fabric access:** minimum 2 cycles (grant, ack). Back-to-back accesses cost 2 cycles each because no grant is made while ack is high. Each I2C strobe adds 1 cycle of fabric stall.
- **Mid-transfer reset:** `rst_n` low mid-transfer clears everything on the next edge. A pending grant produces no ack.

## Test plan
- **Write burst:** start, rx 0x03, 0xA1, 0xB2, stop → reg3=0xA1, reg4=0xB2, `ptr`=5, state IDLE, `reg_wr_o` pulses with idx 3 then 4.
- **Pointer wrap (NUM_REGS=16):** start, rx 0x1F, then 0x11, 0x22 → pointer byte gives `ptr`=15; reg15=0x11, reg0=0x22, `ptr`=1.
- **Combined read:** preload reg7=0x5C, reg8=0x6D; start, rx 0x07, repeated start, two `tx_byte_req` → tx bytes 0x5C then 0x6D, each valid exactly 1 cycle after its request; `ptr`=9.
- **Same-cycle write conflict:** fabric write reg2=0x99 asserted in the same cycle as I2C rx 0x44 to reg2 → the I2C write lands first, `fab_ack_o` is delayed one cycle, final reg2=0x99.
- **Fabric read-back:** after an I2C write of reg5=0x3C, fabric read idx 5 → `fab_ack_o` 2 cycles after `fab_req_i` rises, `fab_rdata_o`=0x3C.
- **Reset and IDLE behaviour:** `rst_n` low for 1 cycle mid-burst → all regs 0, state IDLE, outputs 0. A subsequent rx byte without a start is ignored: no write, no `reg_wr_o`.

Source files
------------

// File: rtl/i2c_reg_ctrl.sv
// Pointer-addressed register bank shared by an I2C byte stream and a local fabric port; 1-cycle I2C latency, 2-cycle fabric access.
// I2C never stalls: fabric waits whenever an I2C strobe is present or its previous ack is still high.
module i2c_reg_ctrl #(
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       i2c_rx_byte_data_i,
  input  logic             i2c_rx_byte_valid_i,
  input  logic             i2c_tx_byte_req_i,
  output logic [7:0]       i2c_tx_byte_data_o,
  output logic             i2c_tx_byte_valid_o,
  input  logic             i2c_transaction_start_i,
  input  logic             i2c_transaction_stop_i,
  input  logic             fab_req_i,
  input  logic             fab_we_i,
  input  logic [IDX_W-1:0] fab_addr_i,
  input  logic [7:0]       fab_wdata_i,
  output logic [7:0]       fab_rdata_o,
  output logic             fab_ack_o,
  output logic             reg_wr_o,
  output logic [IDX_W-1:0] reg_wr_idx_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PTR  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [IDX_W-1:0] ptr;
  logic [7:0]       regs [NUM_REGS];

  logic             i2c_wr;
  logic             ptr_ld;
  logic             ptr_inc;
  logic             i2c_strobe;
  logic             fab_grant;
  logic             bank_we;
  logic [IDX_W-1:0] bank_idx;
  logic [7:0]       bank_dat;

  always_comb begin
    i2c_wr     = i2c_rx_byte_valid_i && (state == ST_DATA);
    ptr_ld     = i2c_rx_byte_valid_i && (state == ST_PTR);
    // A simultaneous rx and tx advances the pointer once; a pointer load takes precedence.
    ptr_inc    = !ptr_ld && (i2c_wr || (i2c_tx_byte_req_i && (state != ST_IDLE)));
    i2c_strobe = i2c_wr || ptr_ld || i2c_tx_byte_req_i;
    fab_grant  = fab_req_i && !i2c_strobe && !fab_ack_o;

    bank_we  = i2c_wr || (fab_grant && fab_we_i);
    bank_idx = i2c_wr ? ptr : fab_addr_i;
    bank_dat = i2c_wr ? i2c_rx_byte_data_i : fab_wdata_i;

    state_nxt = state;
    if (ptr_ld || (i2c_tx_byte_req_i && (state == ST_PTR)))
      state_nxt = ST_DATA;
    if (i2c_transaction_start_i)
      state_nxt = ST_PTR;
    else if (i2c_transaction_stop_i)
      state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state               <= ST_IDLE;
      ptr                 <= '0;
      i2c_tx_byte_data_o  <= '0;
      i2c_tx_byte_valid_o <= 1'b0;
      fab_rdata_o         <= '0;
      fab_ack_o           <= 1'b0;
      reg_wr_o            <= 1'b0;
      reg_wr_idx_o        <= '0;
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else begin
      state <= state_nxt;

      if (ptr_ld)
        ptr <= i2c_rx_byte_data_i[IDX_W-1:0];
      else if (ptr_inc)
        ptr <= ptr + IDX_W'(1);

      if (bank_we)
        regs[bank_idx] <= bank_dat;

      i2c_tx_byte_valid_o <= i2c_tx_byte_req_i;
      if (i2c_tx_byte_req_i)
        i2c_tx_byte_data_o <= regs[ptr];

      reg_wr_o <= i2c_wr;
      if (i2c_wr)
        reg_wr_idx_o <= ptr;

      fab_ack_o <= fab_grant;
      if (fab_grant && !fab_we_i)
        fab_rdata_o <= regs[fab_addr_i];
    end
  end

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Directed bench for i2c_reg_ctrl: write bursts, pointer wrap, combined read, arbitration and reset.
module tb_i2c_reg_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] i2c_rx_byte_data_i;
  logic       i2c_rx_byte_valid_i;
  logic       i2c_tx_byte_req_i;
  logic [7:0] i2c_tx_byte_data_o;
  logic       i2c_tx_byte_valid_o;
  logic       i2c_transaction_start_i;
  logic       i2c_transaction_stop_i;
  logic       fab_req_i;
  logic       fab_we_i;
  logic [3:0] fab_addr_i;
  logic [7:0] fab_wdata_i;
  logic [7:0] fab_rdata_o;
  logic       fab_ack_o;
  logic       reg_wr_o;
  logic [3:0] reg_wr_idx_o;

  int checks = 0;
  int errs   = 0;

  always #5 clk = ~clk;

  i2c_reg_ctrl #(.NUM_REGS(16)) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .i2c_rx_byte_data_i      (i2c_rx_byte_data_i),
    .i2c_rx_byte_valid_i     (i2c_rx_byte_valid_i),
    .i2c_tx_byte_req_i       (i2c_tx_byte_req_i),
    .i2c_tx_byte_data_o      (i2c_tx_byte_data_o),
    .i2c_tx_byte_valid_o     (i2c_tx_byte_valid_o),
    .i2c_transaction_start_i (i2c_transaction_start_i),
    .i2c_transaction_stop_i  (i2c_transaction_stop_i),
    .fab_req_i               (fab_req_i),
    .fab_we_i                (fab_we_i),
    .fab_addr_i              (fab_addr_i),
    .fab_wdata_i             (fab_wdata_i),
    .fab_rdata_o             (fab_rdata_o),
    .fab_ack_o               (fab_ack_o),
    .reg_wr_o                (reg_wr_o),
    .reg_wr_idx_o            (reg_wr_idx_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // All drivers change inputs on the falling edge; the DUT samples them on the next rising edge.
  task automatic pulse_start();
    i2c_transaction_start_i = 1'b1;
    @(negedge clk);
    i2c_transaction_start_i = 1'b0;
  endtask

  task automatic pulse_stop();
    i2c_transaction_stop_i = 1'b1;
    @(negedge clk);
    i2c_transaction_stop_i = 1'b0;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    i2c_rx_byte_data_i  = b;
    i2c_rx_byte_valid_i = 1'b1;
    @(negedge clk);
    i2c_rx_byte_valid_i = 1'b0;
  endtask

  task automatic tx_req();
    i2c_tx_byte_req_i = 1'b1;
    @(negedge clk);
    i2c_tx_byte_req_i = 1'b0;
  endtask

  // lat counts the request cycle as 1, so a grant-then-ack access reports 2.
  task automatic fab_access(input logic we, input logic [3:0] addr, input logic [7:0] wd,
                            output int lat);
    fab_req_i   = 1'b1;
    fab_we_i    = we;
    fab_addr_i  = addr;
    fab_wdata_i = wd;
    lat = 1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      lat++;
      if (fab_ack_o) break;
    end
    if (!fab_ack_o) chk("fab_ack_timeout", 32'd0, 32'd1);
    fab_req_i = 1'b0;
  endtask

  initial begin
    int lat;
    logic [7:0] acc;

    rst_n                   = 1'b0;
    i2c_rx_byte_data_i      = '0;
    i2c_rx_byte_valid_i     = 1'b0;
    i2c_tx_byte_req_i       = 1'b0;
    i2c_transaction_start_i = 1'b0;
    i2c_transaction_stop_i  = 1'b0;
    fab_req_i               = 1'b0;
    fab_we_i                = 1'b0;
    fab_addr_i              = '0;
    fab_wdata_i             = '0;
    repeat (2) @(negedge clk);
    chk("rst_tx_valid", i2c_tx_byte_valid_o, 0);
    chk("rst_tx_data", i2c_tx_byte_data_o, 0);
    chk("rst_fab_ack", fab_ack_o, 0);
    chk("rst_reg_wr", reg_wr_o, 0);
    chk("rst_ptr", dut.ptr, 0);
    chk("rst_state", dut.state, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Write burst
    pulse_start();
    rx_byte(8'h03);
    chk("burst_ptr_no_wr", reg_wr_o, 0);
    rx_byte(8'hA1);
    chk("burst_wr0", reg_wr_o, 1);
    chk("burst_idx0", reg_wr_idx_o, 3);
    rx_byte(8'hB2);
    chk("burst_wr1", reg_wr_o, 1);
    chk("burst_idx1", reg_wr_idx_o, 4);
    pulse_stop();
    chk("burst_wr_end", reg_wr_o, 0);
    chk("burst_reg3", dut.regs[3], 8'hA1);
    chk("burst_reg4", dut.regs[4], 8'hB2);
    chk("burst_ptr", dut.ptr, 5);
    chk("burst_state", dut.state, 0);

    // Pointer wrap
    pulse_start();
    rx_byte(8'h1F);
    chk("wrap_ptr_load", dut.ptr, 15);
    rx_byte(8'h11);
    rx_byte(8'h22);
    chk("wrap_idx", reg_wr_idx_o, 0);
    chk("wrap_reg15", dut.regs[15], 8'h11);
    chk("wrap_reg0", dut.regs[0], 8'h22);
    chk("wrap_ptr", dut.ptr, 1);
    pulse_stop();

    // Combined read after repeated start
    fab_access(1'b1, 4'd7, 8'h5C, lat);
    @(negedge clk);
    fab_access(1'b1, 4'd8, 8'h6D, lat);
    @(negedge clk);
    pulse_start();
    rx_byte(8'h07);
    pulse_start();
    tx_req();
    chk("rd0_valid", i2c_tx_byte_valid_o, 1);
    chk("rd0_data", i2c_tx_byte_data_o, 8'h5C);
    @(negedge clk);
    chk("rd0_valid_drop", i2c_tx_byte_valid_o, 0);
    tx_req();
    chk("rd1_valid", i2c_tx_byte_valid_o, 1);
    chk("rd1_data", i2c_tx_byte_data_o, 8'h6D);
    chk("rd_ptr", dut.ptr, 9);
    pulse_stop();

    // Same-cycle write conflict on reg2
    pulse_start();
    rx_byte(8'h02);
    i2c_rx_byte_data_i  = 8'h44;
    i2c_rx_byte_valid_i = 1'b1;
    fab_req_i   = 1'b1;
    fab_we_i    = 1'b1;
    fab_addr_i  = 4'd2;
    fab_wdata_i = 8'h99;
    @(negedge clk);
    i2c_rx_byte_valid_i = 1'b0;
    chk("conf_i2c_first", dut.regs[2], 8'h44);
    chk("conf_ack_delayed", fab_ack_o, 0);
    @(negedge clk);
    chk("conf_ack", fab_ack_o, 1);
    fab_req_i = 1'b0;
    chk("conf_reg2", dut.regs[2], 8'h99);
    pulse_stop();

    // Fabric read-back of an I2C write
    pulse_start();
    rx_byte(8'h05);
    rx_byte(8'h3C);
    pulse_stop();
    fab_access(1'b0, 4'd5, 8'h00, lat);
    chk("fab_rd_lat", lat, 2);
    chk("fab_rd_data", fab_rdata_o, 8'h3C);
    @(negedge clk);
    chk("fab_ack_pulse", fab_ack_o, 0);
    chk("fab_rd_hold", fab_rdata_o, 8'h3C);

    // Reset mid-burst with a pending fabric read
    pulse_start();
    rx_byte(8'h0A);
    rx_byte(8'h77);
    rst_n = 1'b0;
    i2c_rx_byte_data_i  = 8'h55;
    i2c_rx_byte_valid_i = 1'b1;
    fab_req_i  = 1'b1;
    fab_we_i   = 1'b0;
    fab_addr_i = 4'd10;
    @(negedge clk);
    rst_n = 1'b1;
    i2c_rx_byte_valid_i = 1'b0;
    fab_req_i = 1'b0;
    acc = '0;
    for (int i = 0; i < 16; i++) acc |= dut.regs[i];
    chk("mrst_regs", acc, 0);
    chk("mrst_state", dut.state, 0);
    chk("mrst_ptr", dut.ptr, 0);
    chk("mrst_reg_wr", reg_wr_o, 0);
    chk("mrst_fab_ack", fab_ack_o, 0);
    chk("mrst_fab_rdata", fab_rdata_o, 0);
    @(negedge clk);
    chk("mrst_no_ack", fab_ack_o, 0);
    rx_byte(8'h66);
    chk("idle_rx_no_wr", reg_wr_o, 0);
    chk("idle_rx_reg0", dut.regs[0], 0);
    chk("idle_rx_state", dut.state, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
